// File: rtl/clint_timer.sv
// Core-local interruptor: 64-bit mtime / mtimecmp timer plus MSIP register
// behind a single-cycle-accept, one-cycle-response bus slave port.
// Drives the machine software (msip) and machine timer (mtip) interrupt lines.
module clint_timer #(
    parameter int unsigned TICK_DIV     = 1,
    parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        msip,
    output logic        mtip
);

    // Word offsets (address bits [15:2]) of the mapped registers
    localparam logic [13:0] WA_MSIP     = 14'h0000;
    localparam logic [13:0] WA_MTCMP_LO = 14'h1000;
    localparam logic [13:0] WA_MTCMP_HI = 14'h1001;
    localparam logic [13:0] WA_MTIME_LO = 14'h2FFE;
    localparam logic [13:0] WA_MTIME_HI = 14'h2FFF;

    localparam logic [15:0] PRESC_MAX = 16'(TICK_DIV - 1);

    // Byte-masked merge of write data into an existing 32-bit word
    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  strb
    );
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_val[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_val[8*b +: 8];
            end
        end
        return res;
    endfunction

    logic [63:0] mtime_q,      mtime_d;
    logic [63:0] mtimecmp_q,   mtimecmp_d;
    logic        msip_q,       msip_d;
    logic [15:0] presc_q,      presc_d;
    logic [31:0] shadow_q,     shadow_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q,   resp_err_d;
    logic        mtip_q,       mtip_d;

    logic [13:0] word_addr_s;
    logic        tick_s;
    logic [31:0] rdata_s;
    logic        err_s;
    logic        unused_addr_s;

    // Byte-lane bits of the address are irrelevant: every register is a full word
    assign unused_addr_s = ^req_addr[1:0];
    assign word_addr_s   = req_addr[15:2];

    // Next-state: prescaler, timer increment, bus writes (writes beat ticks) and read mux
    always_comb begin
        tick_s     = (presc_q == PRESC_MAX);
        presc_d    = tick_s ? 16'd0 : (presc_q + 16'd1);
        mtime_d    = tick_s ? (mtime_q + 64'd1) : mtime_q;
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        shadow_d   = shadow_q;
        rdata_s    = 32'd0;
        err_s      = 1'b0;

        if (req_valid) begin
            case (word_addr_s)
                WA_MSIP: begin
                    rdata_s = {31'd0, msip_q};
                    if (req_we && req_wstrb[0]) begin
                        msip_d = req_wdata[0];
                    end else begin
                        msip_d = msip_q;
                    end
                end
                WA_MTCMP_LO: begin
                    rdata_s = mtimecmp_q[31:0];
                    if (req_we) begin
                        mtimecmp_d[31:0] = merge_bytes(mtimecmp_q[31:0], req_wdata, req_wstrb);
                    end else begin
                        mtimecmp_d = mtimecmp_q;
                    end
                end
                WA_MTCMP_HI: begin
                    rdata_s = mtimecmp_q[63:32];
                    if (req_we) begin
                        mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], req_wdata, req_wstrb);
                    end else begin
                        mtimecmp_d = mtimecmp_q;
                    end
                end
                WA_MTIME_LO: begin
                    rdata_s = mtime_q[31:0];
                    if (req_we) begin
                        // Write replaces any tick this cycle; upper half held
                        mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], req_wdata, req_wstrb)};
                    end else begin
                        // Latch the upper half so a following hi read is coherent
                        shadow_d = mtime_q[63:32];
                    end
                end
                WA_MTIME_HI: begin
                    rdata_s = shadow_q;
                    if (req_we) begin
                        mtime_d = {merge_bytes(mtime_q[63:32], req_wdata, req_wstrb), mtime_q[31:0]};
                    end else begin
                        mtime_d = mtime_d;
                    end
                end
                default: begin
                    err_s = 1'b1;
                end
            endcase
        end else begin
            rdata_s = 32'd0;
            err_s   = 1'b0;
        end

        resp_valid_d = req_valid;
        resp_rdata_d = (req_valid && !req_we) ? rdata_s : 32'd0;
        resp_err_d   = err_s;
        mtip_d       = (mtime_q >= mtimecmp_q);
    end

    // State and response registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            mtime_q      <= 64'd0;
            mtimecmp_q   <= MTIMECMP_RST;
            msip_q       <= 1'b0;
            presc_q      <= 16'd0;
            shadow_q     <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
            mtip_q       <= 1'b0;
        end else begin
            mtime_q      <= mtime_d;
            mtimecmp_q   <= mtimecmp_d;
            msip_q       <= msip_d;
            presc_q      <= presc_d;
            shadow_q     <= shadow_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            mtip_q       <= mtip_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign msip       = msip_q;
    assign mtip       = mtip_q;

endmodule
